icache_refill_ctrl: RTL and testbench
=====================================

// Module: icache_refill_ctrl
// PURPOSE
// Fetch-side initiator for the direct-mapped instruction cache. Takes PC requests from IF,
// looks up the cache and returns the instruction on a hit. On a miss it reads 4 bytes from
// the byte-wide memory controller, then writes the assembled word back into the cache.
// Sits between the IF stage, the instruction cache array and the memory-controller read port.
// PARAMETERS
// ADDR_W    32  instruction address width
// INST_W    32  instruction width; always 4 bytes
// BYTE_W     8  memory port data width
// PORTS
// clk              in   1       system clock, rising edge
// rst              in   1       asynchronous reset, active-low
// rdy              in   1       global ready; 0 freezes all state
// req_i            in   1       IF requests instruction at pc_i
// pc_i             in   ADDR_W  requested PC; bits [1:0] are always 00
// flush_i          in   1       branch redirect; cancels the outstanding fetch
// inst_valid_o     out  1       one-cycle pulse: inst_o valid for the latched PC
// inst_o           out  INST_W  returned instruction
// cache_addr_o     out  ADDR_W  lookup/fill address to the cache array
// cache_data_i     in   INST_W  cache read data (combinational from cache_addr_o)
// cache_hit_i      in   1       valid && tag match for cache_addr_o
// cache_we_o       out  1       fill strobe (cache "work")
// cache_wdata_o    out  INST_W  fill word
// mem_req_o        out  1       byte read request, held until the 4th ack
// mem_addr_o       out  ADDR_W  byte address = {pc_q[31:2], cnt}
// mem_byte_i       in   BYTE_W  returned byte, valid with mem_ack_i
// mem_ack_i        in   1       one byte delivered this cycle
// BEHAVIOUR
// - rst low (async): state=IDLE, cnt=0, pc_q=0, buf=0. All outputs 0.
// - rdy=0: no register updates. Outputs hold their current values. mem_ack_i is not sampled.
// - States: IDLE, FETCH, FILL.
// - cache_addr_o = (state==IDLE) ? pc_i : pc_q.
// - IDLE, req_i=1, flush_i=0:
//     - Latch pc_q=pc_i.
//     - On cache_hit_i: next cycle inst_valid_o=1, inst_o=cache_data_i; stay IDLE.
//       Hit latency is 1 cycle, back-to-back hits are allowed.
//     - On a miss: go to FETCH with cnt=0.
// - FETCH:
//     - mem_req_o=1, mem_addr_o={pc_q[31:2],cnt[1:0]}.
//     - Each mem_ack_i writes buf[8*cnt+:8]=mem_byte_i and increments cnt (little-endian).
//     - The ack with cnt==3 moves to FILL. cnt wraps to 0.
//     - mem_req_o drops in the cycle after the 4th ack.
// - FILL (exactly 1 cycle):
//     - cache_we_o=1, cache_addr_o=pc_q, cache_wdata_o=buf.
//     - Next cycle: inst_valid_o=1, inst_o=buf, state=IDLE.
//     - Miss latency = 1 + (4 ack cycles) + 1 + 1 output cycle.
// - req_i in FETCH/FILL is ignored; IF holds its request until inst_valid_o.
// - flush_i has top priority in every state:
//     - Next edge: state=IDLE, cnt=0, mem_req_o=0.
//     - No cache_we_o for a partial word. Any inst_valid_o due next cycle is suppressed.
//     - flush_i together with req_i in IDLE: the request is dropped.
// - mem_ack_i outside FETCH (e.g. a late ack after a flush) is ignored.
// - inst_valid_o and cache_we_o are never high longer than 1 cycle.
// STRUCTURE
// - Shared constants go in config.v: InstAddrBus, InstBus, ByteBus, state encodings (2-bit).
// - Single module, no sub-module. Byte assembly (buf, cnt) is inline.
// - The cache array stays a separate instance wired via the cache_* ports.
// TESTING
// 1. Reset mid-FETCH (rst low at cnt=2) -> all outputs 0 immediately; IDLE after release.
// 2. Hit: preload cache @0x100 with 0x00A00093; req pc=0x100 -> inst_valid_o the next cycle,
//    inst_o=0x00A00093, mem_req_o never rises.
// 3. Miss: req pc=0x204, memory bytes 13,05,10,00 with 1-cycle gaps between acks
//    -> mem_addr_o 0x204..0x207; cache_we_o once with 0x00100513;
//    inst_valid_o in the cycle after FILL.
// 4. Refetch of 0x204 right after test 3 -> hit, 1-cycle latency, no memory traffic.
// 5. flush_i after the 2nd ack of a miss -> mem_req_o low next cycle; a 3rd ack is ignored;
//    no cache_we_o, no inst_valid_o; the following req re-misses cleanly.
// 6. rdy=0 for 3 cycles during FETCH -> cnt, buf and outputs frozen;
//    the fill completes with the correct word once rdy=1.

Source files
------------

// File: rtl/icache_refill_ctrl_pkg.sv
// Shared widths and FSM encoding for the instruction-cache refill controller.
package icache_refill_ctrl_pkg;

    localparam int ADDR_W = 32;
    localparam int INST_W = 32;
    localparam int BYTE_W = 8;
    localparam int LANES  = INST_W / BYTE_W;
    localparam int CNT_W  = $clog2(LANES);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_FILL  = 2'd2
    } state_t;

endpackage

// File: rtl/icache_refill_ctrl.sv
// Fetch-side initiator: serves IF from the direct-mapped I-cache and, on a miss,
// assembles a word from four byte reads and writes it back into the cache.
module icache_refill_ctrl
    import icache_refill_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              req_i,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              flush_i,
    output logic              inst_valid_o,
    output logic [INST_W-1:0] inst_o,
    output logic [ADDR_W-1:0] cache_addr_o,
    input  logic [INST_W-1:0] cache_data_i,
    input  logic              cache_hit_i,
    output logic              cache_we_o,
    output logic [INST_W-1:0] cache_wdata_o,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic [BYTE_W-1:0] mem_byte_i,
    input  logic              mem_ack_i
);

    state_t              state_reg, state_next;
    logic [CNT_W-1:0]    cnt_reg, cnt_next;
    logic [ADDR_W-1:0]   pc_reg, pc_next;
    logic [INST_W-1:0]   fill_buf_reg, fill_buf_next;
    logic                inst_valid_reg, inst_valid_next;
    logic [INST_W-1:0]   inst_reg, inst_next;
    logic                byte_we;

    // A byte is only captured while fetching, unfrozen and not being redirected.
    assign byte_we = rdy && !flush_i && (state_reg == ST_FETCH) && mem_ack_i;

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            assign fill_buf_next[gi*BYTE_W +: BYTE_W] =
                (byte_we && (cnt_reg == CNT_W'(gi))) ? mem_byte_i
                                                     : fill_buf_reg[gi*BYTE_W +: BYTE_W];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= ST_IDLE;
            cnt_reg        <= '0;
            pc_reg         <= '0;
            fill_buf_reg   <= '0;
            inst_valid_reg <= 1'b0;
            inst_reg       <= '0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            pc_reg         <= pc_next;
            fill_buf_reg   <= fill_buf_next;
            inst_valid_reg <= inst_valid_next;
            inst_reg       <= inst_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        pc_next         = pc_reg;
        inst_valid_next = 1'b0;
        inst_next       = inst_reg;
        if (!rdy) begin
            inst_valid_next = inst_valid_reg;
        end else if (flush_i) begin
            // Redirect wins everywhere: drop the fetch and any pending response.
            state_next = ST_IDLE;
            cnt_next   = '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (req_i) begin
                        pc_next = pc_i;
                        if (cache_hit_i) begin
                            inst_valid_next = 1'b1;
                            inst_next       = cache_data_i;
                        end else begin
                            state_next = ST_FETCH;
                            cnt_next   = '0;
                        end
                    end
                end
                ST_FETCH: begin
                    if (mem_ack_i) begin
                        cnt_next = cnt_reg + CNT_W'(1);
                        if (cnt_reg == CNT_W'(LANES - 1)) begin
                            state_next = ST_FILL;
                        end
                    end
                end
                ST_FILL: begin
                    inst_valid_next = 1'b1;
                    inst_next       = fill_buf_reg;
                    state_next      = ST_IDLE;
                end
                default: begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    // Lookup follows the live PC while idle so a hit costs only one cycle.
    assign cache_addr_o  = !rst ? '0 : ((state_reg == ST_IDLE) ? pc_i : pc_reg);
    assign cache_we_o    = (state_reg == ST_FILL);
    assign cache_wdata_o = fill_buf_reg;
    assign mem_req_o     = (state_reg == ST_FETCH);
    assign mem_addr_o    = {pc_reg[ADDR_W-1:CNT_W], cnt_reg};
    assign inst_valid_o  = inst_valid_reg;
    assign inst_o        = inst_reg;

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Scoreboard bench for icache_refill_ctrl with a behavioural direct-mapped cache.
module tb_icache_refill_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy = 1'b1;
    logic        req_i = 1'b0;
    logic [31:0] pc_i = 32'h0;
    logic        flush_i = 1'b0;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] cache_addr_o;
    logic [31:0] cache_data_i;
    logic        cache_hit_i;
    logic        cache_we_o;
    logic [31:0] cache_wdata_o;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic [7:0]  mem_byte_i = 8'h0;
    logic        mem_ack_i = 1'b0;

    int checks = 0;
    int errors = 0;
    int n_valid = 0;
    int n_we = 0;
    int n_memreq = 0;

    logic [31:0] exp_q[$];
    logic [63:0] fill_q[$];

    // Behavioural cache: 64 sets, index addr[7:2], tag addr[31:8].
    logic [31:0] c_data [64];
    logic [23:0] c_tag  [64];
    logic        c_vld  [64] = '{default: 1'b0};
    logic        pl_we = 1'b0;
    logic [31:0] pl_addr = 32'h0;
    logic [31:0] pl_data = 32'h0;

    assign cache_hit_i  = c_vld[cache_addr_o[7:2]] && (c_tag[cache_addr_o[7:2]] == cache_addr_o[31:8]);
    assign cache_data_i = c_data[cache_addr_o[7:2]];

    always @(posedge clk) begin
        if (pl_we) begin
            c_data[pl_addr[7:2]] <= pl_data;
            c_tag[pl_addr[7:2]]  <= pl_addr[31:8];
            c_vld[pl_addr[7:2]]  <= 1'b1;
        end else if (cache_we_o && rdy) begin
            c_data[cache_addr_o[7:2]] <= cache_wdata_o;
            c_tag[cache_addr_o[7:2]]  <= cache_addr_o[31:8];
            c_vld[cache_addr_o[7:2]]  <= 1'b1;
        end
    end

    icache_refill_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .rdy          (rdy),
        .req_i        (req_i),
        .pc_i         (pc_i),
        .flush_i      (flush_i),
        .inst_valid_o (inst_valid_o),
        .inst_o       (inst_o),
        .cache_addr_o (cache_addr_o),
        .cache_data_i (cache_data_i),
        .cache_hit_i  (cache_hit_i),
        .cache_we_o   (cache_we_o),
        .cache_wdata_o(cache_wdata_o),
        .mem_req_o    (mem_req_o),
        .mem_addr_o   (mem_addr_o),
        .mem_byte_i   (mem_byte_i),
        .mem_ack_i    (mem_ack_i)
    );

    always #5 clk = ~clk;

    // Scoreboard monitor: responses and fills are popped as the DUT produces them.
    always @(negedge clk) begin
        if (rst === 1'b1 && rdy) begin
            if (mem_req_o) n_memreq++;
            if (inst_valid_o) begin
                n_valid++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_inst: unexpected inst_valid_o, inst_o=%h", inst_o);
                end else begin
                    logic [31:0] e;
                    e = exp_q.pop_front();
                    $display("inst  inst_o=%h expected=%h", inst_o, e);
                    if (inst_o !== e) begin
                        errors++;
                        $display("FAIL sb_inst: got %h expected %h", inst_o, e);
                    end
                end
            end
            if (cache_we_o) begin
                n_we++;
                checks++;
                if (fill_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_fill: unexpected cache_we_o addr=%h data=%h", cache_addr_o, cache_wdata_o);
                end else begin
                    logic [63:0] f;
                    f = fill_q.pop_front();
                    $display("fill  addr=%h data=%h", cache_addr_o, cache_wdata_o);
                    if ({cache_addr_o, cache_wdata_o} !== f) begin
                        errors++;
                        $display("FAIL sb_fill: got %h/%h expected %h/%h", cache_addr_o, cache_wdata_o, f[63:32], f[31:0]);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ack_byte(input logic [7:0] b, input logic [31:0] exp_addr, input int gap);
        repeat (gap) tick();
        checks++;
        if (mem_req_o !== 1'b1 || mem_addr_o !== exp_addr) begin
            errors++;
            $display("FAIL ack_addr: mem_req_o=%b mem_addr_o=%h expected req=1 addr=%h", mem_req_o, mem_addr_o, exp_addr);
        end
        mem_ack_i  = 1'b1;
        mem_byte_i = b;
        tick();
        mem_ack_i  = 1'b0;
    endtask

    task automatic hit_once(input logic [31:0] pc, input logic [31:0] data);
        int m0;
        int v0;
        m0 = n_memreq;
        v0 = n_valid;
        pc_i  = pc;
        req_i = 1'b1;
        exp_q.push_back(data);
        tick();
        req_i = 1'b0;
        checks++;
        if (inst_valid_o !== 1'b1 || inst_o !== data) begin
            errors++;
            $display("FAIL hit_latency: valid=%b inst=%h expected valid=1 inst=%h", inst_valid_o, inst_o, data);
        end
        tick();
        checks++;
        if (inst_valid_o !== 1'b0 || n_memreq != m0 || n_valid != v0 + 1) begin
            errors++;
            $display("FAIL hit_after: valid=%b memreq_cycles=%0d responses=%0d expected valid=0 memreq=%0d responses=%0d",
                     inst_valid_o, n_memreq - m0, n_valid - v0, 0, 1);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1 rst = 1'b0;
        pc_i = 32'h0000_123C;
        #1;
        checks++;
        if ({inst_valid_o, inst_o, cache_addr_o, cache_we_o, cache_wdata_o, mem_req_o, mem_addr_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%b inst=%h caddr=%h we=%b wdata=%h req=%b maddr=%h expected all 0",
                     inst_valid_o, inst_o, cache_addr_o, cache_we_o, cache_wdata_o, mem_req_o, mem_addr_o);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        tick();
        // Miss to 0x300, then reset with two bytes already collected.
        pc_i  = 32'h300;
        req_i = 1'b1;
        tick();
        req_i = 1'b0;
        ack_byte(8'h01, 32'h300, 0);
        ack_byte(8'h02, 32'h301, 0);
        checks++;
        if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h302) begin
            errors++;
            $display("FAIL reset_pre: req=%b maddr=%h expected req=1 maddr=00000302", mem_req_o, mem_addr_o);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({inst_valid_o, inst_o, cache_addr_o, cache_we_o, cache_wdata_o, mem_req_o, mem_addr_o} !== '0) begin
            errors++;
            $display("FAIL reset_midfetch: valid=%b inst=%h caddr=%h we=%b wdata=%h req=%b maddr=%h expected all 0",
                     inst_valid_o, inst_o, cache_addr_o, cache_we_o, cache_wdata_o, mem_req_o, mem_addr_o);
        end
        tick();
        rst  = 1'b1;
        pc_i = 32'h500;
        tick();
        checks++;
        if (mem_req_o !== 1'b0 || cache_addr_o !== 32'h500 || inst_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: req=%b caddr=%h valid=%b expected req=0 caddr=00000500 valid=0",
                     mem_req_o, cache_addr_o, inst_valid_o);
        end
    endtask

    task automatic test_hit();
        pl_addr = 32'h100;
        pl_data = 32'h00A00093;
        pl_we   = 1'b1;
        tick();
        pl_we   = 1'b0;
        hit_once(32'h100, 32'h00A00093);
    endtask

    task automatic test_miss();
        int w0;
        w0 = n_we;
        pc_i  = 32'h204;
        req_i = 1'b1;
        exp_q.push_back(32'h00100513);
        fill_q.push_back({32'h204, 32'h00100513});
        tick();
        ack_byte(8'h13, 32'h204, 1);
        ack_byte(8'h05, 32'h205, 1);
        ack_byte(8'h10, 32'h206, 1);
        ack_byte(8'h00, 32'h207, 1);
        checks++;
        if (cache_we_o !== 1'b1 || cache_wdata_o !== 32'h00100513 || cache_addr_o !== 32'h204
            || mem_req_o !== 1'b0 || inst_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL miss_fill: we=%b wdata=%h caddr=%h req=%b valid=%b expected we=1 wdata=00100513 caddr=00000204 req=0 valid=0",
                     cache_we_o, cache_wdata_o, cache_addr_o, mem_req_o, inst_valid_o);
        end
        tick();
        req_i = 1'b0;
        checks++;
        if (inst_valid_o !== 1'b1 || inst_o !== 32'h00100513 || cache_we_o !== 1'b0) begin
            errors++;
            $display("FAIL miss_resp: valid=%b inst=%h we=%b expected valid=1 inst=00100513 we=0",
                     inst_valid_o, inst_o, cache_we_o);
        end
        tick();
        checks++;
        if (inst_valid_o !== 1'b0 || n_we != w0 + 1) begin
            errors++;
            $display("FAIL miss_after: valid=%b fills=%0d expected valid=0 fills=1", inst_valid_o, n_we - w0);
        end
    endtask

    task automatic test_refetch();
        hit_once(32'h204, 32'h00100513);
    endtask

    task automatic test_back_to_back();
        pc_i  = 32'h100;
        req_i = 1'b1;
        exp_q.push_back(32'h00A00093);
        tick();
        checks++;
        if (inst_valid_o !== 1'b1 || inst_o !== 32'h00A00093) begin
            errors++;
            $display("FAIL b2b_first: valid=%b inst=%h expected valid=1 inst=00a00093", inst_valid_o, inst_o);
        end
        pc_i = 32'h204;
        exp_q.push_back(32'h00100513);
        tick();
        req_i = 1'b0;
        checks++;
        if (inst_valid_o !== 1'b1 || inst_o !== 32'h00100513) begin
            errors++;
            $display("FAIL b2b_second: valid=%b inst=%h expected valid=1 inst=00100513", inst_valid_o, inst_o);
        end
        // A redirect arriving with a request drops that request.
        pc_i    = 32'h100;
        req_i   = 1'b1;
        flush_i = 1'b1;
        tick();
        req_i   = 1'b0;
        flush_i = 1'b0;
        checks++;
        if (inst_valid_o !== 1'b0 || mem_req_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_with_req: valid=%b req=%b expected valid=0 req=0", inst_valid_o, mem_req_o);
        end
        tick();
    endtask

    task automatic test_flush();
        int v0;
        int w0;
        v0 = n_valid;
        w0 = n_we;
        pc_i  = 32'h308;
        req_i = 1'b1;
        tick();
        req_i = 1'b0;
        ack_byte(8'h11, 32'h308, 0);
        ack_byte(8'h22, 32'h309, 0);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        checks++;
        if (mem_req_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_req_drop: mem_req_o=%b expected 0", mem_req_o);
        end
        mem_ack_i  = 1'b1;
        mem_byte_i = 8'h33;
        tick();
        mem_ack_i  = 1'b0;
        repeat (3) tick();
        checks++;
        if (n_valid != v0 || n_we != w0 || mem_req_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_quiet: responses=%0d fills=%0d req=%b expected 0 0 0", n_valid - v0, n_we - w0, mem_req_o);
        end
        pc_i  = 32'h308;
        req_i = 1'b1;
        exp_q.push_back(32'hDDCCBBAA);
        fill_q.push_back({32'h308, 32'hDDCCBBAA});
        tick();
        ack_byte(8'hAA, 32'h308, 0);
        ack_byte(8'hBB, 32'h309, 0);
        ack_byte(8'hCC, 32'h30A, 0);
        ack_byte(8'hDD, 32'h30B, 0);
        checks++;
        if (cache_we_o !== 1'b1 || cache_wdata_o !== 32'hDDCCBBAA) begin
            errors++;
            $display("FAIL flush_refill: we=%b wdata=%h expected we=1 wdata=ddccbbaa", cache_we_o, cache_wdata_o);
        end
        tick();
        req_i = 1'b0;
        tick();
    endtask

    task automatic test_rdy();
        pc_i  = 32'h40C;
        req_i = 1'b1;
        exp_q.push_back(32'h44332211);
        fill_q.push_back({32'h40C, 32'h44332211});
        tick();
        req_i = 1'b0;
        ack_byte(8'h11, 32'h40C, 0);
        ack_byte(8'h22, 32'h40D, 0);
        rdy        = 1'b0;
        mem_ack_i  = 1'b1;
        mem_byte_i = 8'hEE;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h40E || cache_we_o !== 1'b0 || inst_valid_o !== 1'b0) begin
                errors++;
                $display("FAIL rdy_freeze[%0d]: req=%b maddr=%h we=%b valid=%b expected req=1 maddr=0000040e we=0 valid=0",
                         i, mem_req_o, mem_addr_o, cache_we_o, inst_valid_o);
            end
        end
        rdy       = 1'b1;
        mem_ack_i = 1'b0;
        ack_byte(8'h33, 32'h40E, 0);
        ack_byte(8'h44, 32'h40F, 0);
        checks++;
        if (cache_we_o !== 1'b1 || cache_wdata_o !== 32'h44332211) begin
            errors++;
            $display("FAIL rdy_fill: we=%b wdata=%h expected we=1 wdata=44332211", cache_we_o, cache_wdata_o);
        end
        tick();
        checks++;
        if (inst_valid_o !== 1'b1 || inst_o !== 32'h44332211) begin
            errors++;
            $display("FAIL rdy_resp: valid=%b inst=%h expected valid=1 inst=44332211", inst_valid_o, inst_o);
        end
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_hit();
        test_miss();
        test_refetch();
        test_back_to_back();
        test_flush();
        test_rdy();
        repeat (2) tick();
        checks++;
        if (exp_q.size() != 0 || fill_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: pending responses=%0d fills=%0d expected 0 0", exp_q.size(), fill_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
